// File: rtl/pwm_pkg.sv
// pwm_pkg: types and default sizes shared by the PWM bank and other
// timer blocks.
//   pwm_mode_e      - counting mode (edge-aligned up-count, center-aligned up/down)
//   PWM_*_DEF       - default channel count, resolution and prescaler width
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam int PWM_NCH_DEF  = 4;
    localparam int PWM_R_DEF    = 10;
    localparam int PWM_PS_W_DEF = 16;

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: free-running tick divider, reusable by other timer blocks.
//   clk, rst  - clock, asynchronous active-high reset
//   en        - low holds the counter at 0 and suppresses steps
//   prescale  - one step every prescale+1 cycles
//   step      - combinational, high in the cycle where ps == prescale
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PS_W = PWM_PS_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [PS_W-1:0] prescale,
    output logic            step
);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        ps_d = '0;
        step = 1'b0;
        if (en) begin
            if (ps_q == prescale) begin
                step = 1'b1;
            end else if (ps_q < prescale) begin
                ps_d = ps_q + PS_W'(1);
            end
            // ps_q above a freshly lowered prescale falls to 0 without a step.
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: NCH-channel PWM generator sharing one period counter.
//   clk, rst     - clock, asynchronous active-high reset
//   en           - global enable; low clears counting, outputs = pol
//   prescale     - counter advances once every prescale+1 cycles
//   center       - 0 edge-aligned, 1 center-aligned (applied at a boundary)
//   top_din/top_wr            - period top shadow write
//   duty_wr/duty_ch/duty_din  - per-channel duty shadow write
//   pol          - per-channel output inversion
//   pwm_out      - registered channel outputs
//   period_tick  - one-cycle pulse after each period boundary
module pwm_bank
    import pwm_pkg::*;
#(
    parameter  int NCH   = PWM_NCH_DEF,
    parameter  int PWM_R = PWM_R_DEF,
    parameter  int PS_W  = PWM_PS_W_DEF,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PS_W-1:0]  prescale,
    input  logic             center,
    input  logic [PWM_R-1:0] top_din,
    input  logic             top_wr,
    input  logic             duty_wr,
    input  logic [CH_W-1:0]  duty_ch,
    input  logic [PWM_R-1:0] duty_din,
    input  logic [NCH-1:0]   pol,
    output logic [NCH-1:0]   pwm_out,
    output logic             period_tick
);

    logic [PWM_R-1:0]          top_shd_q,  top_shd_d;
    logic [PWM_R-1:0]          top_act_q,  top_act_d;
    logic [NCH-1:0][PWM_R-1:0] duty_shd_q, duty_shd_d;
    logic [NCH-1:0][PWM_R-1:0] duty_act_q, duty_act_d;
    pwm_mode_e                 mode_shd_q, mode_shd_d;
    pwm_mode_e                 mode_act_q, mode_act_d;
    logic [PWM_R-1:0]          cnt_q,      cnt_d;
    logic                      dir_down_q, dir_down_d;
    logic                      tick_q,     tick_d;
    logic [NCH-1:0]            out_q,      out_d;

    logic step;
    logic boundary;
    logic load;

    pwm_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .prescale (prescale),
        .step     (step)
    );

    // Period counter. A boundary is any step on which cnt lands on 0.
    always_comb begin
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        boundary   = 1'b0;
        if (!en) begin
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else if (step) begin
            if (mode_act_q == PWM_EDGE) begin
                dir_down_d = 1'b0;
                if (cnt_q >= top_act_q) begin
                    cnt_d    = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q + PWM_R'(1);
                end
            end else if (top_act_q == '0) begin
                // Degenerate center period: cnt parks at 0, every step wraps.
                cnt_d      = '0;
                dir_down_d = 1'b0;
                boundary   = 1'b1;
            end else if (dir_down_q ? (cnt_q != '0) : (cnt_q >= top_act_q)) begin
                cnt_d = cnt_q - PWM_R'(1);
                if (cnt_q == PWM_R'(1)) begin
                    boundary   = 1'b1;
                    dir_down_d = 1'b0;
                end else begin
                    dir_down_d = 1'b1;
                end
            end else begin
                cnt_d      = cnt_q + PWM_R'(1);
                dir_down_d = 1'b0;
            end
        end
    end

    // Shadow/active registers. Active values load from the pre-write shadow,
    // so a write landing on a boundary shows up one period later. While
    // disabled the shadows are mirrored into the active set every cycle.
    assign load = !en || boundary;

    always_comb begin
        top_shd_d  = top_wr ? top_din : top_shd_q;
        duty_shd_d = duty_shd_q;
        if (duty_wr && (int'(duty_ch) < NCH)) begin
            duty_shd_d[duty_ch] = duty_din;
        end
        mode_shd_d = center ? PWM_CENTER : PWM_EDGE;

        top_act_d  = load ? top_shd_q  : top_act_q;
        duty_act_d = load ? duty_shd_q : duty_act_q;
        mode_act_d = load ? mode_shd_q : mode_act_q;
        tick_d     = boundary;
    end

    // Compare stage: outputs are registered, one cycle behind cnt.
    always_comb begin
        out_d = pol;
        if (en) begin
            for (int i = 0; i < NCH; i++) begin
                out_d[i] = (cnt_q < duty_act_q[i]) ^ pol[i];
            end
        end
    end

    // NOTE: the duty arrays are reset like plain registers because the active
    // values must read 0 straight out of reset; a real RAM would not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_shd_q  <= '0;
            top_act_q  <= '0;
            duty_shd_q <= '0;
            duty_act_q <= '0;
            mode_shd_q <= PWM_EDGE;
            mode_act_q <= PWM_EDGE;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            tick_q     <= 1'b0;
            out_q      <= '0;
        end else begin
            top_shd_q  <= top_shd_d;
            top_act_q  <= top_act_d;
            duty_shd_q <= duty_shd_d;
            duty_act_q <= duty_act_d;
            mode_shd_q <= mode_shd_d;
            mode_act_q <= mode_act_d;
            cnt_q      <= cnt_d;
            dir_down_q <= dir_down_d;
            tick_q     <= tick_d;
            out_q      <= out_d;
        end
    end

    assign pwm_out     = out_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench for pwm_bank. A step-index reference model
// predicts pwm_out/period_tick for every cycle; predictions are queued when
// the stimulus is driven and compared after the clock edge. Directed counts
// (high time, tick spacing, first-period length) are checked against
// hand-derived constants.
module tb_pwm_bank;
    import pwm_pkg::*;

    localparam int NCH   = 3;
    localparam int PWM_R = PWM_R_DEF;
    localparam int PS_W  = PWM_PS_W_DEF;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [PS_W-1:0]  prescale;
    logic             center;
    logic [PWM_R-1:0] top_din;
    logic             top_wr;
    logic             duty_wr;
    logic [CH_W-1:0]  duty_ch;
    logic [PWM_R-1:0] duty_din;
    logic [NCH-1:0]   pol;
    logic [NCH-1:0]   pwm_out;
    logic             period_tick;

    always #5 clk = ~clk;

    pwm_bank #(
        .NCH   (NCH),
        .PWM_R (PWM_R),
        .PS_W  (PS_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .prescale    (prescale),
        .center      (center),
        .top_din     (top_din),
        .top_wr      (top_wr),
        .duty_wr     (duty_wr),
        .duty_ch     (duty_ch),
        .duty_din    (duty_din),
        .pol         (pol),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    typedef struct packed {
        logic [NCH-1:0] out;
        logic           tick;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: position in the period is a step index k; cnt is
    // derived from k rather than tracked with a direction flag.
    int m_ps, m_k;
    int m_top_shd, m_top_act;
    int m_duty_shd [NCH];
    int m_duty_act [NCH];
    bit m_mode_shd, m_mode_act;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ps = 0; m_k = 0;
        m_top_shd = 0; m_top_act = 0;
        m_mode_shd = 1'b0; m_mode_act = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_duty_shd[i] = 0;
            m_duty_act[i] = 0;
        end
    endtask

    task automatic m_load();
        m_top_act  = m_top_shd;
        m_mode_act = m_mode_shd;
        for (int i = 0; i < NCH; i++) m_duty_act[i] = m_duty_shd[i];
    endtask

    function automatic int m_cnt();
        if (m_mode_act) return (m_k <= m_top_act) ? m_k : 2 * m_top_act - m_k;
        return m_k;
    endfunction

    function automatic int m_plen();
        if (!m_mode_act) return m_top_act + 1;
        return (m_top_act == 0) ? 1 : 2 * m_top_act;
    endfunction

    // One clock: predict, push, clock, pop and compare. Strobes last one cycle.
    task automatic cyc();
        exp_t e;
        bit   stp;
        for (int i = 0; i < NCH; i++) begin
            e.out[i] = en ? ((m_cnt() < m_duty_act[i]) ^ pol[i]) : pol[i];
        end
        e.tick = 1'b0;
        if (!en) begin
            m_ps = 0;
            m_k  = 0;
            m_load();
        end else begin
            stp = (m_ps == int'(prescale));
            if (m_ps >= int'(prescale)) m_ps = 0;
            else m_ps++;
            if (stp) begin
                m_k = (m_k + 1) % m_plen();
                if (m_k == 0) begin
                    e.tick = 1'b1;
                    m_load();
                end
            end
        end
        m_mode_shd = center;
        if (top_wr) m_top_shd = int'(top_din);
        if (duty_wr && int'(duty_ch) < NCH) m_duty_shd[duty_ch] = int'(duty_din);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        top_wr  = 1'b0;
        duty_wr = 1'b0;
        e = sb_q.pop_front();
        check("pwm_out", 32'(pwm_out), 32'(e.out));
        check("period_tick", 32'(period_tick), 32'(e.tick));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr_top(input int v);
        top_din = PWM_R'(v);
        top_wr  = 1'b1;
        cyc();
    endtask

    task automatic wr_duty(input int ch, input int v);
        duty_ch  = CH_W'(ch);
        duty_din = PWM_R'(v);
        duty_wr  = 1'b1;
        cyc();
    endtask

    task automatic wait_ticks(input int n, input int budget);
        int seen = 0;
        int c    = 0;
        while (seen < n && c < budget) begin
            cyc();
            c++;
            if (period_tick) seen++;
        end
        if (seen < n) check("tick_timeout", seen, n);
    endtask

    task automatic measure(input int n, input int ch, output int hi, output int ticks, output int gap);
        int last = -1;
        hi = 0; ticks = 0; gap = 0;
        for (int c = 0; c < n; c++) begin
            cyc();
            if (pwm_out[ch]) hi++;
            if (period_tick) begin
                ticks++;
                if (last >= 0) gap = c - last;
                last = c;
            end
        end
    endtask

    initial begin
        int hi, tk, gap, c, bad;

        rst = 1'b1; en = 1'b0; center = 1'b0; prescale = '0;
        top_din = '0; top_wr = 1'b0; duty_wr = 1'b0; duty_ch = '0; duty_din = '0;
        pol = '0;
        m_reset();
        #1;
        check("reset_pwm_out", 32'(pwm_out), 0);
        check("reset_tick", 32'(period_tick), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Edge mode, top 9, duty 3: 3 high / 7 low, tick every 10 cycles.
        wr_top(9);
        wr_duty(0, 3);
        wr_duty(1, 5);
        wr_duty(2, 12);
        cyc();
        en = 1'b1;
        measure(30, 0, hi, tk, gap);
        check("edge_high_30", hi, 9);
        check("edge_ticks_30", tk, 3);
        check("edge_tick_gap", gap, 10);

        // Mid-period duty write waits for the boundary.
        run(4);
        wr_duty(0, 7);
        wait_ticks(1, 20);
        measure(10, 0, hi, tk, gap);
        check("duty7_high", hi, 7);
        check("duty7_ticks", tk, 1);
        // Write on the boundary cycle itself: one more period at 7, then 2.
        run(9);
        wr_duty(0, 2);
        measure(10, 0, hi, tk, gap);
        check("bnd_write_old", hi, 7);
        measure(10, 0, hi, tk, gap);
        check("bnd_write_new", hi, 2);

        // Inverted channel 1: duty 0 -> constant high, duty 15 -> constant low.
        pol = 3'b010;
        wr_duty(1, 0);
        wait_ticks(1, 20);
        measure(20, 1, hi, tk, gap);
        check("pol_duty0_high", hi, 20);
        wr_duty(1, 15);
        wait_ticks(1, 20);
        measure(20, 1, hi, tk, gap);
        check("pol_duty15_high", hi, 0);

        // Drop enable mid-period, then re-raise: first period is full length.
        run(4);
        en = 1'b0;
        cyc();
        check("en_low_out", 32'(pwm_out), 32'(pol));
        run(2);
        en = 1'b1;
        c = 0;
        do begin
            cyc();
            c++;
        end while (!period_tick && c < 40);
        check("first_period_len", c, 10);

        // Center mode, prescale 1, top 4, duty 2: cnt<2 on 3 of 8 steps,
        // 2 clk each -> 6 of 16 cycles high, tick every 16 cycles.
        pol = '0;
        center = 1'b1;
        prescale = PS_W'(1);
        wr_top(4);
        wr_duty(0, 2);
        wait_ticks(2, 80);
        measure(32, 0, hi, tk, gap);
        check("center_high_32", hi, 12);
        check("center_ticks_32", tk, 2);
        check("center_tick_gap", gap, 16);

        // Prescale lowered below the running ps value.
        prescale = PS_W'(5);
        run(4);
        prescale = PS_W'(1);
        run(12);
        prescale = PS_W'(3);
        run(3);
        prescale = '0;
        run(12);

        // Reset mid-period is asynchronous and leaves everything at 0.
        center = 1'b0;
        wr_top(9);
        wr_duty(0, 3);
        wr_duty(1, 6);
        pol = 3'b011;
        wait_ticks(1, 40);
        run(4);
        #2 rst = 1'b1;
        #1;
        check("rst_async_out", 32'(pwm_out), 0);
        check("rst_async_tick", 32'(period_tick), 0);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        run(3);

        // Out-of-range channel write must not touch any channel.
        pol = '0;
        wr_duty(3, 5);
        bad = 0;
        repeat (10) begin
            cyc();
            if (pwm_out != '0) bad++;
        end
        check("bad_ch_no_effect", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
